// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal reorder buffer: bank states and default sizes.
package bitrev_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_LOG2N  = 6;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

endpackage

// File: rtl/bitrev_addr.sv
// Purely combinational LOG2N-bit address reversal (bit i of the input lands on bit LOG2N-1-i).
module bitrev_addr
   import bitrev_pkg::*;
#(
   parameter int LOG2N = DEF_LOG2N
) (
   input  logic [LOG2N-1:0] addr,
   output logic [LOG2N-1:0] rev_addr
);

   always_comb begin
      rev_addr = '0;
      for (int i = 0; i < LOG2N; i++) begin
         rev_addr[i] = addr[LOG2N-1-i];
      end
   end

endmodule

// File: rtl/bitrev_reorder.sv
// Frame reorder buffer: natural-order samples in, bit-reversed-order samples out.
// Define BITREV_PINGPONG_EN for two banks (fill one while draining the other); default is a single bank.
module bitrev_reorder
   import bitrev_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LOG2N  = DEF_LOG2N
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int N = 1 << LOG2N;
`ifdef BITREV_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   logic [DATA_W-1:0] mem [NB][N];
   bank_state_t       bank_st [NB];
   logic              wb;
   logic              rb;
   logic [LOG2N-1:0]  wcnt;
   logic [LOG2N-1:0]  rcnt;
   logic [LOG2N-1:0]  raddr;
   logic              rdy_en;
   logic              wen;
   logic              ren;
   logic              rd_avail;

   bitrev_addr #(.LOG2N(LOG2N)) u_rev (
      .addr     (rcnt),
      .rev_addr (raddr)
   );

   // rdy_en keeps in_ready low until the first edge after reset releases.
   assign in_ready = rdy_en && ((bank_st[wb] == BANK_EMPTY) || (bank_st[wb] == BANK_FILLING));
   assign rd_avail = (bank_st[rb] == BANK_FULL) || (bank_st[rb] == BANK_DRAINING);
   assign wen      = in_valid && in_ready;
   assign ren      = rd_avail && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (wen) begin
         mem[wb][wcnt] <= in_data;
      end
   end

   // Write and read never touch the same bank in one cycle, so their state updates cannot collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en    <= 1'b0;
         wb        <= 1'b0;
         rb        <= 1'b0;
         wcnt      <= '0;
         rcnt      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         for (int b = 0; b < NB; b++) begin
            bank_st[b] <= BANK_EMPTY;
         end
      end else begin
         rdy_en <= 1'b1;
         if (wen) begin
            wcnt <= wcnt + LOG2N'(1);
            if (wcnt == '1) begin
               bank_st[wb] <= BANK_FULL;
               if (NB == 2) begin
                  wb <= ~wb;
               end
            end else begin
               bank_st[wb] <= BANK_FILLING;
            end
         end
         if (ren) begin
            out_data  <= mem[rb][raddr];
            out_valid <= 1'b1;
            out_last  <= (rcnt == '1);
            rcnt      <= rcnt + LOG2N'(1);
            if (rcnt == '1) begin
               bank_st[rb] <= BANK_EMPTY;
               if (NB == 2) begin
                  rb <= ~rb;
               end
            end else begin
               bank_st[rb] <= BANK_DRAINING;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed and randomised checks of bitrev_reorder with LOG2N = 3; expectations follow BITREV_PINGPONG_EN.
module tb_bitrev_reorder;

   localparam int DW    = 16;
   localparam int LG    = 3;
   localparam int N     = 1 << LG;
   localparam int TOTAL = 8000;
`ifdef BITREV_PINGPONG_EN
   localparam int STREAM_STALLS = 0;
   localparam int STALL_ACCEPTS = 16;
`else
   localparam int STREAM_STALLS = 24;
   localparam int STALL_ACCEPTS = 8;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;

   int errors = 0;
   int checks = 0;
   int chk_idx = 0;
   int tbl [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

   always #5 clk = ~clk;

   bitrev_reorder #(.DATA_W(DW), .LOG2N(LG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   function automatic int brev(input int m);
      int r = 0;
      for (int i = 0; i < LG; i++) begin
         if (m[i]) r = r | (1 << (LG - 1 - i));
      end
      return r;
   endfunction

   // Reference model: collects accepted frames and records observed handshakes.
   logic [DW-1:0] frame_buf [$];
   logic [DW-1:0] exp_q [$];
   logic          exp_last_q [$];
   logic [DW-1:0] obs_q [$];
   logic          obs_last_q [$];
   int            obs_cyc_q [$];
   int            cyc = 0;
   int            acc_cnt = 0;
   int            stall_cnt = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         frame_buf.delete();
         while (exp_q.size() > obs_q.size()) begin
            void'(exp_q.pop_back());
            void'(exp_last_q.pop_back());
         end
      end else begin
         if (in_valid && in_ready) begin
            acc_cnt++;
            frame_buf.push_back(in_data);
            if (frame_buf.size() == N) begin
               for (int m = 0; m < N; m++) begin
                  exp_q.push_back(frame_buf[brev(m)]);
                  exp_last_q.push_back(m == N - 1);
               end
               frame_buf.delete();
            end
         end
         if (in_valid && !in_ready) stall_cnt++;
         if (out_valid && out_ready) begin
            obs_q.push_back(out_data);
            obs_last_q.push_back(out_last);
            obs_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [DW-1:0] d);
      int t = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) checkOutput("stim_timeout", 64'(t), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int t = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      while ((out_valid || obs_q.size() < exp_q.size()) && t < 500) begin
         @(negedge clk);
         t++;
      end
      checkOutput("drain_count", 64'(obs_q.size()), 64'(exp_q.size()));
      @(posedge clk);
      #1;
   endtask

   task automatic checkStream(input string tag);
      for (int i = chk_idx; i < obs_q.size(); i++) begin
         if (i < exp_q.size()) begin
            checkOutput({tag, "_data"}, 64'(obs_q[i]), 64'(exp_q[i]));
            checkOutput({tag, "_last"}, 64'(obs_last_q[i]), 64'(exp_last_q[i]));
         end
      end
      chk_idx = obs_q.size();
   endtask

   initial begin
      int base;
      int n;
      int s0;
      logic have;
      logic acc;
      logic [DW-1:0] held;

      $display("[TB] reset checks");
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_last", 64'(out_last), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_before_edge", 64'(in_ready), 64'd0);
      @(negedge clk);
      checkOutput("in_ready_after_edge", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      $display("[TB] single frame order and latency");
      out_ready = 1'b1;
      base = obs_q.size();
      for (int k = 0; k < N; k++) applyStimulus(DW'(k));
      @(negedge clk);
      checkOutput("latency_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      checkOutput("latency_first", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      waitDrain();
      for (int m = 0; m < N; m++) begin
         if (base + m < obs_q.size()) begin
            checkOutput("order_data", 64'(obs_q[base + m]), 64'(tbl[m]));
            checkOutput("order_last", 64'(obs_last_q[base + m]), 64'(m == N - 1));
         end
      end
      checkStream("order");

      $display("[TB] four frames streamed");
      s0 = stall_cnt;
      base = obs_q.size();
      for (int k = 0; k < 4 * N; k++) applyStimulus(DW'(16'h100 + k));
      waitDrain();
      checkStream("stream4");
      checkOutput("stream4_stalls", 64'(stall_cnt - s0), 64'(STREAM_STALLS));
`ifdef BITREV_PINGPONG_EN
      if (base + 31 < obs_cyc_q.size())
         checkOutput("stream4_gap", 64'(obs_cyc_q[base + 31] - obs_cyc_q[base]), 64'd31);
`endif

      $display("[TB] output stall for 20 cycles");
      out_ready = 1'b0;
      s0 = acc_cnt;
      n = 0;
      have = 1'b0;
      held = '0;
      in_valid = 1'b1;
      in_data = DW'(16'h200);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) n++;
         if (out_valid) begin
            if (!have) begin
               held = out_data;
               have = 1'b1;
            end else begin
               checkOutput("stall_hold", 64'(out_data), 64'(held));
            end
         end
         @(posedge clk);
         #1;
         in_data = DW'(16'h200 + n);
      end
      in_valid = 1'b0;
      checkOutput("stall_accepted", 64'(acc_cnt - s0), 64'(STALL_ACCEPTS));
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_first_data", 64'(out_data), 64'h200);
      checkOutput("stall_last", 64'(out_last), 64'd0);
      waitDrain();
      checkStream("stall");

      $display("[TB] reset mid-frame");
      for (int k = 0; k < 5; k++) applyStimulus(DW'(16'h400 + k));
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_ready_back", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      base = obs_q.size();
      for (int k = 0; k < N; k++) applyStimulus(DW'(16'h500 + k));
      waitDrain();
      checkOutput("midrst_count", 64'(obs_q.size() - base), 64'(N));
      for (int m = 0; m < N; m++) begin
         if (base + m < obs_q.size())
            checkOutput("midrst_order", 64'(obs_q[base + m]), 64'(16'h500 + tbl[m]));
      end
      checkStream("midrst");

      $display("[TB] random traffic, 1000 frames");
      n = 0;
      s0 = 0;
      in_valid = 1'b0;
      while (n < TOTAL && s0 < 80000) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) n++;
         @(posedge clk);
         #1;
         s0++;
         out_ready = ($urandom_range(0, 1) == 1);
         if (acc || !in_valid) begin
            in_valid = (n < TOTAL) && ($urandom_range(0, 1) == 1);
            in_data  = DW'(n);
         end
      end
      in_valid = 1'b0;
      checkOutput("random_sent", 64'(n), 64'(TOTAL));
      waitDrain();
      checkStream("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bitrev_reorder.md
BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 64, sample width in bits.
REQ-002 SHALL have parameter LOG2N, default 6, log2 of frame length N (N = 2**LOG2N, LOG2N range 1..10).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  DATA_W  sample in natural order.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  DATA_W  sample in bit-reversed order.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_last  output  1  high with the final sample (index N-1) of each output frame.

Function
REQ-012 SHALL accept a sample only when in_valid and in_ready are both high, and emit one when out_valid and out_ready are both high.
REQ-013 SHALL treat every N consecutive accepted samples as one frame; there is no input framing signal.
REQ-014 SHALL write accepted sample k (0..N-1) to address k of the write bank.
REQ-015 SHALL output sample m (0..N-1) of a frame from address bitrev(m), the LOG2N-bit reversal of m.
REQ-016 SHALL track each bank with states EMPTY -> FILLING (first write) -> FULL (write of k = N-1) -> DRAINING (first read) -> EMPTY (read of m = N-1).
REQ-017 SHALL assert out_valid the cycle after a bank enters FULL, giving a minimum latency of 1 cycle from the last input of a frame to the first output.
REQ-018 SHALL hold out_data, out_last and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL deassert in_ready when no bank is EMPTY or FILLING.
REQ-020 SHALL, when a fill completes and a drain completes in the same cycle, swap the bank roles with no idle cycle on either side.
REQ-021 SHALL keep out_data registered, so that no combinational path exists from in_* to out_*.

Reset
REQ-022 SHALL, while rst_n = 0, force in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, all bank states to EMPTY, and write/read counters to 0.
REQ-023 SHALL discard any partial or undrained frame on reset assertion mid-operation; memory contents need not be cleared.
REQ-024 SHALL drive in_ready = 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with BITREV_PINGPONG_EN defined, use two N-entry banks so that frame n+1 fills while frame n drains (sustained throughput 1 sample/cycle).
REQ-026 SHALL, without BITREV_PINGPONG_EN, use one bank and hold in_ready = 0 from FULL until that bank returns to EMPTY (throughput about 0.5 sample/cycle).

Structure
REQ-027 SHALL place the bank-state enum and the default DATA_W/LOG2N constants in the shared package bitrev_pkg.
REQ-028 SHALL implement address reversal as the parameterised sub-module bitrev_addr (LOG2N-bit input, LOG2N-bit reversed output, purely combinational).

Verification
REQ-029 SHALL cover this case: LOG2N = 3, inputs 0..7 back-to-back, out_ready = 1 -> outputs 0,4,2,6,1,5,3,7, out_last high on the 7.
REQ-030 SHALL cover this case: LOG2N = 3, pingpong on, 4 frames streamed continuously -> in_ready never low and 32 outputs with no gap after the first.
REQ-031 SHALL cover this case: out_ready = 0 for 20 cycles with pingpong on -> in_ready drops after 16 accepted samples, and out_data stays stable throughout.
REQ-032 SHALL cover this case: pingpong off, 2 frames offered -> in_ready low for 8 cycles between the frames, and output order is correct.
REQ-033 SHALL cover this case: rst_n pulsed low after 5 of 8 inputs -> out_valid = 0 and the next 8 inputs form a fresh frame output as 0,4,2,6,1,5,3,7 (relative indices).
REQ-034 SHALL cover this case: random in_valid/out_ready at 50% over 1000 frames -> scoreboard matches bitrev order, with no loss or duplication.
